// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply/divide unit for HI/LO.
//   One operation at a time, start/busy/done handshake, WIDTH+2 cycles per op:
//   PREP (take operand magnitudes), CALC (WIDTH shift-add or restoring-divide
//   iterations), FIX (apply signs, load results).
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   start, op         new request, sampled only in IDLE;
//                     op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1, src2        multiplicand/dividend, multiplier/divisor
//   flush             abort any operation in flight (no done, results kept)
//   busy              high in PREP, CALC and FIX
//   done              one-cycle pulse when res_hi/res_lo/div_by_zero update
//   res_hi, res_lo    MULT: product high/low; DIV: remainder/quotient
//   div_by_zero       DIV/DIVU with src2==0, held until the next done
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, raw_a;
  logic [2*WIDTH:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res, neg_rem;

  logic               is_div, is_signed, last_iter;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
  logic               rem_ge;
  logic [2*WIDTH:0]   acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               dz;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) in the unsigned view.
  assign sgn_a = is_signed & a_r[WIDTH-1];
  assign sgn_b = is_signed & b_r[WIDTH-1];
  assign abs_a = sgn_a ? -a_r : a_r;
  assign abs_b = sgn_b ? -b_r : b_r;

  // Multiply: acc = {partial product (W+1), remaining multiplier bits (W)}.
  // The extra top bit keeps the add carry so 2^(W-1)*2^(W-1) is exact.
  assign add_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, a_r} : '0);

  // Divide: acc = {remainder (W+1), dividend/quotient (W)}; restoring step.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, b_r});
  assign rem_diff = rem_sh - {1'b0, b_r};

  always_comb begin
    acc_step = acc;
    if (is_div) acc_step = {(rem_ge ? rem_diff : rem_sh), acc[WIDTH-2:0], rem_ge};
    else        acc_step = {1'b0, add_sum, acc[WIDTH-1:1]};
  end

  // Sign fix-up; quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    prod = acc[2*WIDTH-1:0];
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (neg_res) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_rem) rem = -rem;
  end

  // b_r already holds |src2|, which is zero exactly when src2 is.
  assign dz = is_div && (b_r == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = PREP;
      PREP: state_nxt = CALC;
      CALC: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      raw_a       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      done        <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !flush) begin
          op_r  <= op;
          a_r   <= src1;
          b_r   <= src2;
          raw_a <= src1;
        end
        PREP: begin
          a_r     <= abs_a;
          b_r     <= abs_b;
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= is_div & sgn_a;
          acc     <= {{(WIDTH+1){1'b0}}, (is_div ? abs_a : abs_b)};
          cnt     <= '0;
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!flush) begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (dz) begin
            res_hi <= raw_a;
            res_lo <= '1;
          end else if (is_div) begin
            res_hi <= rem;
            res_lo <= quo;
          end else begin
            res_hi <= prod[2*WIDTH-1:WIDTH];
            res_lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, start8, flush8;
  logic [1:0]  op, op8;
  logic [31:0] src1, src2;
  logic [7:0]  s1_8, s2_8;
  logic        busy, done, dz, busy8, done8, dz8;
  logic [31:0] hi, lo;
  logic [7:0]  hi8, lo8;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .busy(busy), .done(done), .res_hi(hi), .res_lo(lo),
    .div_by_zero(dz)
  );

  muldiv_iter #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .src1(s1_8), .src2(s2_8),
    .flush(flush8), .busy(busy8), .done(done8), .res_hi(hi8), .res_lo(lo8),
    .div_by_zero(dz8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop the oldest expectation whenever done pulses.
  always @(negedge clk) begin
    if (done) begin
      if (q32.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        chk("hi32", 64'(hi), 64'(e.hi));
        chk("lo32", 64'(lo), 64'(e.lo));
        chk("dz32", 64'(dz), 64'(e.dz));
        chk("latency32", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("hi8", 64'(hi8), 64'(e.hi));
        chk("lo8", 64'(lo8), 64'(e.lo));
        chk("dz8", 64'(dz8), 64'(e.dz));
        chk("latency8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; the start is sampled at the next posedge and done
  // is expected WIDTH+2 cycles after that edge.
  task automatic issue(input bit w8, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    if (w8) begin
      start8 = 1'b1; op8 = o; s1_8 = a[7:0]; s2_8 = b[7:0];
      e.cyc = cyc + 8 + 3;
      if (push) q8.push_back(e);
    end else begin
      start = 1'b1; op = o; src1 = a; src2 = b;
      e.cyc = cyc + 32 + 3;
      if (push) q32.push_back(e);
    end
  endtask

  // Drops start after one cycle, counts busy cycles, returns in the done cycle.
  task automatic wait_done(input bit w8, output int nb);
    bit seen;
    nb = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; start8 = 1'b0; end
      if (w8 ? busy8 : busy) nb++;
      if (w8 ? done8 : done) seen = 1;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic void ref8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] rh, output logic [7:0] rl, output logic rdz);
    int sa, sb, ua, ub, p, q, r;
    sa = $signed(a); sb = $signed(b); ua = int'(a); ub = int'(b);
    rdz = 1'b0;
    p = 0; q = 0; r = 0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: if (b != 0) begin q = sa / sb; r = sa % sb; end
      default: if (b != 0) begin q = ua / ub; r = ua % ub; end
    endcase
    if (o[1]) begin
      if (b == 0) begin rdz = 1'b1; rh = a; rl = 8'hFF; end
      else begin rh = r[7:0]; rl = q[7:0]; end
    end else begin
      rh = p[15:8]; rl = p[7:0];
    end
  endfunction

  initial begin
    int nb;
    logic [7:0] rh, rl, ra, rb;
    logic rdz;
    logic [1:0] ro;
    reset = 1'b1;
    start = 0; flush = 0; op = 0; src1 = 0; src2 = 0;
    start8 = 0; flush8 = 0; op8 = 0; s1_8 = 0; s2_8 = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MULTU max*max, latency and busy length
    issue(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0);
    wait_done(0, nb);
    chk("busy_cycles32", 64'(nb), 64'd34);
    chk("busy_in_done", 64'(busy), 64'd0);

    // 2: MULT -3*5, then back-to-back DIV -7/2 in the done cycle
    issue(0, 2'b00, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    wait_done(0, nb);
    issue(0, 2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    wait_done(0, nb);
    // more signed corners: 7/-2, min*min, DIVU, signed divide by zero
    issue(0, 2'b10, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 0);
    wait_done(0, nb);
    issue(0, 2'b00, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0, 0);
    wait_done(0, nb);
    issue(0, 2'b11, 32'hFFFFFFFF, 32'h10, 1, 32'hF, 32'h0FFFFFFF, 0);
    wait_done(0, nb);
    issue(0, 2'b10, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    wait_done(0, nb);

    // 3: DIVU by zero, then 100/7 clears the flag
    issue(0, 2'b11, 32'd100, 32'd0, 1, 32'd100, 32'hFFFFFFFF, 1);
    wait_done(0, nb);
    issue(0, 2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
    wait_done(0, nb);

    // 4: flush in CALC cycle 10 -- no done, results unchanged
    @(negedge clk);
    issue(0, 2'b01, 32'd3, 32'd4, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_after_flush", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("hi_kept", 64'(hi), 64'd2);
    chk("lo_kept", 64'(lo), 64'd14);
    chk("dz_kept", 64'(dz), 64'd0);
    // start+flush in IDLE is dropped
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("busy_start_flush", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // 5: async reset mid-CALC, then signed overflow divide
    issue(0, 2'b11, 32'd1000, 32'd3, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0);
    wait_done(0, nb);

    // 6: WIDTH=8 corners, then reference-model sweep
    @(negedge clk);
    issue(1, 2'b00, 32'h80, 32'h80, 1, 32'h40, 32'h00, 0);
    wait_done(1, nb);
    chk("busy_cycles8", 64'(nb), 64'd10);
    issue(1, 2'b10, 32'h81, 32'h03, 1, 32'hFF, 32'hD6, 0);
    wait_done(1, nb);
    for (int i = 0; i < 2000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      if (i % 97 == 0) begin ra = 8'h80; rb = 8'hFF; end
      ref8(ro, ra, rb, rh, rl, rdz);
      issue(1, ro, {24'b0, ra}, {24'b0, rb}, 1, {24'b0, rh}, {24'b0, rl}, rdz);
      wait_done(1, nb);
    end

    repeat (3) @(negedge clk);
    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q8_empty", 64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
